// File: rtl/uart_tx_ctrl_if.sv
// User-side byte stream into the UART transmit controller: valid/ready handshake plus data word.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: baud tick counter plus bit counter serialising one word per frame
// (start, data LSB-first, optional parity, stop bits) onto a registered tx line.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_W       = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam int unsigned     BitW     = 4;
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              accept;
  logic              bit_end;

  assign accept       = (state_q == StIdle) && bus.tx_valid;
  assign bit_end      = (cnt_q == CntMax);
  assign bus.tx_ready = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign tx           = tx_q;
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) begin
          shreg_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ PARITY_ODD;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            state_d = PARITY_EN ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state being entered so each bit starts on its entering edge.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: five parameter sets share clk/rst; frames are checked cycle by cycle
// against a frame-bit model computed from the frame layout.
module tb_uart_tx_ctrl;

  localparam int NCFG = 5;

  // Configs: 0 base, 1 even parity, 2 odd parity, 3 two stop bits, 4 C=2 W=9 odd parity 2 stop.
  function automatic int unsigned cfg_c(input int g);
    return (g == 4) ? 2 : 4;
  endfunction
  function automatic int unsigned cfg_w(input int g);
    return (g == 4) ? 9 : 8;
  endfunction
  function automatic int unsigned cfg_p(input int g);
    return (g == 1 || g == 2 || g == 4) ? 1 : 0;
  endfunction
  function automatic int unsigned cfg_o(input int g);
    return (g == 2 || g == 4) ? 1 : 0;
  endfunction
  function automatic int unsigned cfg_s(input int g);
    return (g == 3 || g == 4) ? 2 : 1;
  endfunction
  function automatic int frame_bits(input int g);
    return 1 + int'(cfg_w(g)) + int'(cfg_p(g)) + int'(cfg_s(g));
  endfunction

  logic            clk;
  logic            rst;
  logic [8:0]      data_r [NCFG];
  logic [NCFG-1:0] valid_r;
  logic [NCFG-1:0] tx_w, busy_w, done_w, ready_w;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned W = cfg_w(g);
    uart_tx_ctrl_if #(.DATA_W(W)) bus ();
    assign bus.tx_data  = data_r[g][W-1:0];
    assign bus.tx_valid = valid_r[g];
    assign ready_w[g]   = bus.tx_ready;
    uart_tx_ctrl #(
      .CLKS_PER_BIT (cfg_c(g)),
      .DATA_W       (W),
      .PARITY_EN    (cfg_p(g) != 0),
      .PARITY_ODD   (cfg_o(g) != 0),
      .STOP_BITS    (cfg_s(g))
    ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .tx   (tx_w[g]),
      .busy (busy_w[g]),
      .done (done_w[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line level k edges after acceptance: frame bit index is k / CLKS_PER_BIT.
  function automatic int exp_tx(input int g, input logic [8:0] d, input int k);
    int b, w, ones;
    b = k / int'(cfg_c(g));
    w = int'(cfg_w(g));
    if (b == 0) return 0;
    if (b <= w) return int'(d[b-1]);
    if (cfg_p(g) != 0 && b == w + 1) begin
      ones = 0;
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      return (ones % 2) ^ int'(cfg_o(g));
    end
    return 1;
  endfunction

  function automatic int exp_par(input int g, input logic [8:0] d);
    return exp_tx(g, d, (int'(cfg_w(g)) + 1) * int'(cfg_c(g)));
  endfunction

  task automatic check_idle(input int g, input string tag);
    chk($sformatf("%s tx cfg%0d", tag, g), int'(tx_w[g]), 1);
    chk($sformatf("%s busy cfg%0d", tag, g), int'(busy_w[g]), 0);
    chk($sformatf("%s done cfg%0d", tag, g), int'(done_w[g]), 0);
    chk($sformatf("%s ready cfg%0d", tag, g), int'(ready_w[g]), 1);
  endtask

  // Called at a negedge; accepts on the next posedge and ends at the negedge of the done cycle.
  task automatic run_frame(input int g, input logic [8:0] d, input bit hold,
                           output int done_cyc, output int par_seen);
    int c, last;
    c        = int'(cfg_c(g));
    last     = frame_bits(g) * c;
    done_cyc = -1;
    par_seen = -1;
    data_r[g]  = d;
    valid_r[g] = 1'b1;
    chk($sformatf("ready before accept cfg%0d", g), int'(ready_w[g]), 1);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) valid_r[g] = 1'b0;
      if (k == 2 * c) data_r[g] = 9'($urandom);
      chk($sformatf("tx cfg%0d word %0h k=%0d", g, d, k), int'(tx_w[g]), exp_tx(g, d, k));
      chk($sformatf("busy cfg%0d k=%0d", g, k), int'(busy_w[g]), int'(k < last));
      chk($sformatf("done cfg%0d k=%0d", g, k), int'(done_w[g]), int'(k == last));
      chk($sformatf("ready cfg%0d k=%0d", g, k), int'(ready_w[g]), int'(k == last));
      if (done_w[g] && done_cyc < 0) done_cyc = k + 1;
      if (k == (int'(cfg_w(g)) + 1) * c) par_seen = int'(tx_w[g]);
    end
  endtask

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         exp_done;
    int         exp_par;   // -1 when the config has no parity bit
  } vec_t;

  initial begin
    vec_t vecs [9];
    int   dc, dc2, ps;
    bit   hold;

    vecs[0] = '{cfg: 0, data: 9'h0A5, exp_done: 41, exp_par: -1};
    vecs[1] = '{cfg: 0, data: 9'h000, exp_done: 41, exp_par: -1};
    vecs[2] = '{cfg: 0, data: 9'h0FF, exp_done: 41, exp_par: -1};
    vecs[3] = '{cfg: 1, data: 9'h007, exp_done: 45, exp_par: 1};
    vecs[4] = '{cfg: 2, data: 9'h007, exp_done: 45, exp_par: 0};
    vecs[5] = '{cfg: 1, data: 9'h000, exp_done: 45, exp_par: 0};
    vecs[6] = '{cfg: 2, data: 9'h000, exp_done: 45, exp_par: 1};
    vecs[7] = '{cfg: 3, data: 9'h03C, exp_done: 45, exp_par: -1};
    vecs[8] = '{cfg: 4, data: 9'h1FF, exp_done: 27, exp_par: 0};

    rst     = 1'b0;
    valid_r = '0;
    for (int g = 0; g < NCFG; g++) data_r[g] = '0;

    // Reset state, then idle with tx_valid low.
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) check_idle(g, "reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle(0, "idle");
    end
    for (int g = 1; g < NCFG; g++) check_idle(g, "idle end");

    // Table-driven single frames.
    foreach (vecs[i]) begin
      run_frame(vecs[i].cfg, vecs[i].data, 1'b0, dc, ps);
      chk($sformatf("done cycle vec%0d", i), dc, vecs[i].exp_done);
      if (vecs[i].exp_par >= 0) chk($sformatf("parity bit vec%0d", i), ps, vecs[i].exp_par);
      repeat (2) @(negedge clk);
    end

    // Back-to-back with tx_valid held: second accept on the done cycle.
    run_frame(0, 9'h055, 1'b1, dc, ps);
    run_frame(0, 9'h00F, 1'b0, dc2, ps);
    chk("b2b first done cycle", dc, 41);
    chk("b2b second done cycle", dc2, 41);
    @(negedge clk);
    check_idle(0, "after b2b");

    // Asynchronous reset during data bit 3 aborts the frame at once.
    data_r[0]  = 9'h0A5;
    valid_r[0] = 1'b1;
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-abort busy", int'(busy_w[0]), 1);
    #2 rst = 1'b0;
    #1;
    check_idle(0, "abort");
    data_r[0]  = 9'h03C;
    valid_r[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(0, "valid in reset");
    end
    rst = 1'b1;
    run_frame(0, 9'h03C, 1'b0, dc, ps);
    chk("post-reset done cycle", dc, 41);
    @(negedge clk);

    // Randomised frames, optionally back-to-back, with random idle gaps.
    for (int g = 0; g < NCFG; g++) begin
      for (int i = 0; i < 6; i++) begin
        hold = (i < 5) && ($urandom_range(0, 1) == 1);
        run_frame(g, 9'($urandom), hold, dc, ps);
        chk($sformatf("rand done cycle cfg%0d", g), dc, frame_bits(g) * int'(cfg_c(g)) + 1);
        if (!hold) begin
          repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check_idle(g, "rand gap");
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
